// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: ALU op encoding (must match the execute ALU), opcodes, funct codes, ID/EX layout.
// No logic or state of its own; backpressure is not applicable.
package decode_stage_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SRA = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic branch_ne;
        logic jal;
        logic jalr;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu_op;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } id_ex_t;

    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opc);
        imm_fmt_t fmt;
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    // funct7[5] only means SUB for register-register ops; ADDI ignores it.
    function automatic logic [3:0] alu_op_of(input logic [2:0] f3, input logic alt, input logic is_reg);
        logic [3:0] op;
        case (f3)
            F3_ADD:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Instruction word to sign-extended 32-bit immediate, selected by the opcode's format.
// Purely combinational, zero latency; no backpressure.
module decode_stage_imm_gen
    import decode_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (imm_fmt_of(instr_i[6:0]))
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I-subset decode: regfile read, operand/ALU-op select, ID/EX register; one cycle IF/ID -> ID/EX.
// ex_stall holds ID/EX, load-use inserts a one-cycle bubble; both raise id_stall unless ex_flush kills ID.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ex_stall,
    input  logic            ex_flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [3:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_operand_a,
    output logic [XLEN-1:0] ex_operand_b,
    output logic [4:0]      ex_rs1_addr,
    output logic [4:0]      ex_rs2_addr,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_branch_ne,
    output logic            ex_jal,
    output logic            ex_jalr,
    output logic            ex_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [31:0] imm;

    id_ex_t dec;
    ctrl_t  ctrl;
    logic   legal;
    logic   writes_rd;
    logic   uses_rs2;
    logic   is_shift;
    logic   rs1_used;
    logic   rs2_used;
    logic   load_use;

    id_ex_t ex_q;
    id_ex_t ex_d;

    assign opcode   = if_instr[6:0];
    assign funct3   = if_instr[14:12];
    assign funct7   = if_instr[31:25];
    assign rd_field = if_instr[11:7];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    decode_stage_imm_gen u_imm_gen (
        .instr_i (if_instr),
        .imm_o   (imm)
    );

    always_comb begin
        dec           = '0;
        ctrl          = '0;
        legal         = 1'b0;
        writes_rd     = 1'b0;
        uses_rs2      = 1'b0;
        is_shift      = (funct3 == F3_SLL) || (funct3 == F3_SR);
        dec.alu_op    = ALU_ADD;
        dec.operand_a = rs1_data;
        dec.operand_b = imm;
        dec.rs1_addr  = rs1_addr;
        dec.rs2_addr  = rs2_addr;
        dec.rs2_data  = rs2_data;
        dec.imm       = imm;
        dec.pc        = if_pc;

        case (opcode)
            OPC_OP: begin
                legal = (funct3 != F3_SLTU) &&
                        ((funct7 == F7_BASE) ||
                         ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))));
                dec.alu_op    = alu_op_of(funct3, funct7[5], 1'b1);
                dec.operand_b = rs2_data;
                writes_rd     = 1'b1;
                uses_rs2      = 1'b1;
            end
            OPC_OP_IMM: begin
                legal = (funct3 != F3_SLTU) &&
                        (!is_shift || (funct7 == F7_BASE) ||
                         ((funct3 == F3_SR) && (funct7 == F7_ALT)));
                dec.alu_op = alu_op_of(funct3, funct7[5], 1'b0);
                if (is_shift) begin
                    dec.operand_b = {27'b0, if_instr[24:20]};
                end
                writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                legal         = (funct3 == F3_LW);
                ctrl.mem_read = 1'b1;
                writes_rd     = 1'b1;
            end
            OPC_STORE: begin
                legal          = (funct3 == F3_SW);
                ctrl.mem_write = 1'b1;
                uses_rs2       = 1'b1;
            end
            OPC_BRANCH: begin
                legal          = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
                dec.alu_op     = ALU_SUB;
                dec.operand_b  = rs2_data;
                ctrl.branch    = 1'b1;
                ctrl.branch_ne = (funct3 == F3_BNE);
                uses_rs2       = 1'b1;
            end
            OPC_JAL: begin
                legal         = 1'b1;
                dec.operand_a = if_pc;
                dec.operand_b = 32'd4;
                ctrl.jal      = 1'b1;
                writes_rd     = 1'b1;
            end
            OPC_JALR: begin
                legal         = (funct3 == F3_JALR);
                dec.operand_a = if_pc;
                dec.operand_b = 32'd4;
                ctrl.jalr     = 1'b1;
                writes_rd     = 1'b1;
            end
            OPC_LUI: begin
                legal         = 1'b1;
                dec.operand_a = '0;
                writes_rd     = 1'b1;
            end
            OPC_AUIPC: begin
                legal         = 1'b1;
                dec.operand_a = if_pc;
                writes_rd     = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // Illegal words carry no side effects downstream, only the trap flag.
        if (!legal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            writes_rd    = 1'b0;
            uses_rs2     = 1'b0;
            dec.alu_op   = ALU_ADD;
        end
        ctrl.reg_write = writes_rd && (rd_field != 5'd0);
        dec.rd         = writes_rd ? rd_field : 5'd0;
        dec.valid      = if_valid;
        dec.ctrl       = if_valid ? ctrl : '0;
    end

    assign rs1_used = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign rs2_used = legal && uses_rs2;

    assign load_use = ex_q.valid && ex_q.ctrl.mem_read && (ex_q.rd != 5'd0) && if_valid &&
                      ((rs1_used && (rs1_addr == ex_q.rd)) || (rs2_used && (rs2_addr == ex_q.rd)));

    assign id_stall = (ex_stall || load_use) && !ex_flush;

    always_comb begin
        ex_d = ex_q;
        if (ex_flush) begin
            ex_d = '0;
        end else if (ex_stall) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
        end else begin
            ex_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_operand_a = ex_q.operand_a;
    assign ex_operand_b = ex_q.operand_b;
    assign ex_rs1_addr  = ex_q.rs1_addr;
    assign ex_rs2_addr  = ex_q.rs2_addr;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_imm       = ex_q.imm;
    assign ex_pc        = ex_q.pc;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_write = ex_q.ctrl.reg_write;
    assign ex_mem_read  = ex_q.ctrl.mem_read;
    assign ex_mem_write = ex_q.ctrl.mem_write;
    assign ex_branch    = ex_q.ctrl.branch;
    assign ex_branch_ne = ex_q.ctrl.branch_ne;
    assign ex_jal       = ex_q.ctrl.jal;
    assign ex_jalr      = ex_q.ctrl.jalr;
    assign ex_illegal   = ex_q.ctrl.illegal;

endmodule
